fixed_point_resizer: RTL
========================

Name: fixed_point_resizer

Overview:
- Parametrised, pipelined fixed-point format converter for the filter datapath. Generalises the registered N-to-2N sign-extender.
- Converts a signed Q(IN_W-IN_FRAC).IN_FRAC sample to a signed Q(OUT_W-OUT_FRAC).OUT_FRAC sample.
- Supports widening (sign extension, zero-fill of fraction) and narrowing (truncate or round, then wrap or saturate).
- Valid/ready handshake with back-pressure; optional saturation event counter.

Parameters:
- IN_W, 24, input sample width (two's complement)
- IN_FRAC, 10, input fractional bits (0 to IN_W-1)
- OUT_W, 16, output sample width (two's complement)
- OUT_FRAC, 4, output fractional bits (0 to OUT_W-1)
- CNT_W, 16, saturation counter width (used only with the optional feature)

Ports:
- CLK  input  1  single clock, rising edge
- RESET  input  1  asynchronous, active-high reset
- in_valid  input  1  input sample valid
- in_ready  output  1  block can accept a sample this cycle
- in_data  input  IN_W  signed input sample
- mode  input  2  bit0: 1=round half-up, 0=truncate; bit1: 1=saturate, 0=wrap; sampled with in_data
- out_valid  output  1  output sample valid
- out_ready  input  1  downstream accepts output
- out_data  output  OUT_W  signed converted sample
- sat_flag  output  1  sticky, set when any accepted sample saturated or wrapped out of range
- sat_clr  input  1  synchronous clear of sat_flag and sat_cnt
- sat_cnt  output  CNT_W  saturation event count (0 when feature absent)

Behaviour:
- Clock and reset: one clock, CLK; reset is asynchronous and active-high, RESET.
- Reset values: out_valid=0, out_data=0, sat_flag=0, sat_cnt=0, all pipeline valids=0. in_ready=1 as soon as RESET deasserts.
- Reset mid-operation discards all in-flight samples; none are emitted.
- Pipeline: two register stages, S1 and S2; S2 drives the outputs.
  - A stage loads when it is empty or its contents move on that cycle.
  - in_ready = !S1_valid | S1_advances.
  - S2 advances when out_ready | !out_valid.
  - Latency: 2 cycles from accepted input to out_valid with no stall. Throughput: 1 sample/cycle.
- Stall: with out_valid=1 and out_ready=0, out_data is held stable and the pipeline holds; at most 2 samples are buffered.
- S1, alignment (d = IN_FRAC - OUT_FRAC):
  - d<=0: left-shift by -d, sign-extended to IN_W+1-d bits; rounding has no effect.
  - d>0 with mode[0]=1: add 2^(d-1) in IN_W+1 bits (no overflow), then arithmetic right-shift by d.
  - d>0 with mode[0]=0: arithmetic right-shift by d (floor toward -inf).
  - mode is registered alongside the data.
- S2, range reduction:
  - Range check: aligned value A vs [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - mode[1]=1: clamp to 0x7FF..F or 0x800..0.
  - mode[1]=0: keep the low OUT_W bits (wrap).
  - Either way, out-of-range sets sat_flag and increments sat_cnt when the sample enters S2.
- sat_cnt saturates at all-ones and never wraps.
- sat_clr with a simultaneous event: the clear wins for that cycle, and the event is not counted.
- Pure widening (OUT_W-OUT_FRAC >= IN_W-IN_FRAC and OUT_FRAC >= IN_FRAC) is never out of range. sat_flag stays 0.

Optional Feature:
- Macro: RESIZER_SAT_COUNT_EN.
- Defined: sat_cnt is a CNT_W-bit saturating counter as described above.
- Undefined: no counter is built, and sat_cnt is driven constant 0. sat_flag behaviour is unchanged.

Test Plan:
- Defaults, mode=00, in_data=0x000400 -> out_data=0x0010 two cycles later; sat_flag=0.
- in_data=0x000420: mode=00 -> 0x0010; mode=01 -> 0x0011. in_data=0xFFFFE0 with mode=01 -> 0x0000.
- in_data=0x7FFFFF, mode=11 -> 0x7FFF, sat_flag=1, sat_cnt=1. in_data=0x800000, mode=10 -> 0x8000, sat_cnt=2. in_data=0x7FFFFF, mode=01 -> 0x0000 (wrap), sat_cnt=3. Then sat_clr pulse -> sat_flag=0, sat_cnt=0.
- Back-pressure: stream 5 samples, hold out_ready=0 for 4 cycles mid-stream -> in_ready drops after 2 buffered, out_data stable, all 5 emitted in order with no loss or duplication.
- Widening instance IN_W=24, IN_FRAC=0, OUT_W=48, OUT_FRAC=0, in_data=0x800001 -> out_data=0xFFFFFF800001; sat_flag stays 0.
- Assert RESET asynchronously with 2 samples in flight -> out_valid drops immediately, outputs at reset values, nothing emitted after release until new input.

Source files
------------

// File: rtl/fixed_point_resizer.sv
// fixed_point_resizer: two-stage signed fixed-point format converter with valid/ready handshake.
// Ports: CLK, RESET (async, active-high); in_valid/in_ready/in_data/mode form the input side;
// out_valid/out_ready/out_data form the output side; sat_flag is a sticky out-of-range flag,
// sat_clr clears it and sat_cnt; sat_cnt counts out-of-range samples only when
// RESIZER_SAT_COUNT_EN is defined, otherwise it is tied to 0.
module fixed_point_resizer #(
  parameter int IN_W     = 24,
  parameter int IN_FRAC  = 10,
  parameter int OUT_W    = 16,
  parameter int OUT_FRAC = 4,
  parameter int CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             sat_flag,
  input  logic             sat_clr,
  output logic [CNT_W-1:0] sat_cnt
);
  localparam int D  = IN_FRAC - OUT_FRAC;
  localparam int AW = D <= 0 ? IN_W + 1 - D : IN_W + 1;
  localparam int CW = (AW > OUT_W ? AW : OUT_W) + 1;
  localparam logic [CW-1:0] MX = {{(CW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic [CW-1:0] MN = ~MX;
  logic [AW-1:0] al, s1_a;
  logic [CW-1:0] ax;
  logic [OUT_W-1:0] red;
  logic s1_v, s1_sat, oor, s2_adv, evt;
  generate
    if (D <= 0) begin : g_left
      logic unused_rnd;
      assign unused_rnd = mode[0];
      assign al = {{(AW-IN_W){in_data[IN_W-1]}}, in_data} << (-D);
    end else begin : g_right
      localparam logic [IN_W:0] HALF = (IN_W+1)'(1) << (D-1);
      logic [IN_W:0] x;
      // one guard bit keeps the rounding add from overflowing
      assign x = {in_data[IN_W-1], in_data} + (mode[0] ? HALF : '0);
      assign al = $signed(x) >>> D;
    end
  endgenerate
  assign ax = {{(CW-AW){s1_a[AW-1]}}, s1_a};
  assign oor = $signed(ax) > $signed(MX) || $signed(ax) < $signed(MN);
  assign red = oor && s1_sat ? (ax[CW-1] ? MN[OUT_W-1:0] : MX[OUT_W-1:0]) : ax[OUT_W-1:0];
  assign s2_adv = out_ready | !out_valid;
  assign in_ready = !s1_v | s2_adv;
  assign evt = s2_adv & s1_v & oor;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      s1_v      <= 1'b0;
      s1_a      <= '0;
      s1_sat    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      sat_flag  <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_v <= in_valid;
        if (in_valid) begin
          s1_a   <= al;
          s1_sat <= mode[1];
        end
      end
      if (s2_adv) begin
        out_valid <= s1_v;
        if (s1_v) out_data <= red;
      end
      sat_flag <= !sat_clr & (sat_flag | evt);
    end
`ifdef RESIZER_SAT_COUNT_EN
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) sat_cnt <= '0;
    else sat_cnt <= sat_clr ? '0 : (evt && !(&sat_cnt)) ? sat_cnt + 1'b1 : sat_cnt;
`else
  assign sat_cnt = '0;
`endif
endmodule
